// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - accumulates COUNT adder sums per result behind valid/ready handshakes
// Define SUM_ACC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module sum_accumulator #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 16,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(COUNT - 1);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [7:0]       cnt;
  logic             ovf_acc;

  logic [ACC_W:0]   sum;
  logic             carry;
  logic [ACC_W-1:0] next_acc;
  logic             accept;

  always_comb begin
    sum   = {1'b0, acc} + {{(ACC_W + 1 - IN_W){1'b0}}, in_data};
    carry = sum[ACC_W];
`ifdef SUM_ACC_SATURATE_EN
    // Once a result has overflowed it stays pinned at all ones until it is emitted.
    next_acc = (carry | ovf_acc) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    next_acc = sum[ACC_W-1:0];
`endif
  end

  // in_ready is a register, so out_ready never reaches it combinationally.
  assign accept = in_valid & in_ready;
  assign busy   = (cnt != 8'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_ACC;
      acc       <= '0;
      cnt       <= '0;
      ovf_acc   <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ST_ACC: begin
          if (clear) begin
            // clear takes priority over a sample accepted in the same cycle
            acc     <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
          end else if (accept) begin
            if (cnt == LAST_CNT) begin
              out_data  <= next_acc;
              out_ovf   <= ovf_acc | carry;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
              acc       <= '0;
              cnt       <= '0;
              ovf_acc   <= 1'b0;
              state     <= ST_HOLD;
            end else begin
              acc     <= next_acc;
              cnt     <= cnt + 8'd1;
              ovf_acc <= ovf_acc | carry;
            end
          end
        end
        ST_HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_ACC;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

endmodule
